// File: rtl/attn_pkg.sv
// Shared attention-datapath helpers: mask constant, packed-row lane access.
// Fixed-point: scores carry FRAC fractional bits; rows fit in ROW_MAX bits.
package attn_pkg;

    localparam int ROW_MAX = 512;
    localparam int FRAC    = 8;

    typedef logic [ROW_MAX-1:0] row_t;

    // Most-negative signed value of the given width, zero-extended.
    function automatic logic [31:0] mask_neg(input int w);
        return 32'(1) << (w - 1);
    endfunction

    function automatic logic [31:0] get_lane(
        input row_t r,
        input int   j,
        input int   w
    );
        return 32'(r >> (j * w)) & ((32'(1) << w) - 32'(1));
    endfunction

    function automatic row_t set_lane(
        input row_t        r,
        input int          j,
        input int          w,
        input logic [31:0] v
    );
        row_t m;
        row_t d;
        m = row_t'((64'(1) << w) - 64'(1)) << (j * w);
        d = row_t'(v & ((32'(1) << w) - 32'(1))) << (j * w);
        return (r & ~m) | d;
    endfunction

endpackage

// File: rtl/softmax.sv
// Combinational row softmax, base-2: weight = 2^(OW-1) >> floor(max - x), prob = weight * 2^(OW-1) / sum.
// Ports: data_i packed signed scores (FRAC fraction bits), data_o packed unsigned probabilities (1.0 = 2^(OW-1)).
module softmax
    import attn_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int IW          = 16,
    parameter int OW          = 16
) (
    input  logic [IW*DATA_LENGTH-1:0] data_i,
    output logic [OW*DATA_LENGTH-1:0] data_o
);

    localparam int KW = IW + 1;
    localparam int SW = OW + $clog2(DATA_LENGTH) + 1;
    localparam int NW = 2 * OW + $clog2(DATA_LENGTH) + 1;
    localparam logic [OW-1:0] WONE = {1'b1, {(OW-1){1'b0}}};

    always_comb begin
        logic signed [IW-1:0] x [DATA_LENGTH];
        logic        [OW-1:0] w [DATA_LENGTH];
        logic signed [IW-1:0] mx;
        logic        [KW-1:0] d;
        logic        [SW-1:0] sum;
        for (int j = 0; j < DATA_LENGTH; j++) begin
            x[j] = IW'(get_lane(row_t'(data_i), j, IW));
        end
        mx = x[0];
        for (int j = 1; j < DATA_LENGTH; j++) begin
            if (x[j] > mx) mx = x[j];
        end
        sum = '0;
        for (int j = 0; j < DATA_LENGTH; j++) begin
            // Difference is non-negative, so one extra bit holds it unsigned.
            d    = {mx[IW-1], mx} - {x[j][IW-1], x[j]};
            d    = d >> FRAC;
            w[j] = (d < KW'(OW)) ? (WONE >> d) : '0;
            sum  = sum + SW'(w[j]);
        end
        // The max lane always contributes WONE, so sum is never zero.
        data_o = '0;
        for (int j = 0; j < DATA_LENGTH; j++) begin
            data_o[j*OW +: OW] = OW'((NW'(w[j]) << (OW - 1)) / NW'(sum));
        end
    end

endmodule

// File: rtl/softmax_pipe_stage.sv
// Single valid/ready register stage; ready looks through an empty or draining slot.
// Ports: in_valid_i/in_ready_o/in_data_i upstream, out_valid_o/out_ready_i/out_data_o downstream.
module softmax_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/mat_softmax_stream.sv
// Row-streaming softmax: S1 = masked row + last + row index, S2 = softmax result.
// Ports: in_* / out_* valid-ready row streams, mask_en causal request, err_last sticky framing error.
module mat_softmax_stream
    import attn_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ROW_IN            = 8,
    parameter int COL_IN            = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mask_en,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [INPUT_DATA_WIDTH*COL_IN-1:0]  in_row,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUTPUT_DATA_WIDTH*COL_IN-1:0] out_row,
    output logic                                out_last,
    output logic                                err_last
);

    localparam int IW  = INPUT_DATA_WIDTH;
    localparam int OW  = OUTPUT_DATA_WIDTH;
    localparam int RW  = IW * COL_IN;
    localparam int ORW = OW * COL_IN;
    localparam int CW  = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
    localparam int S1W = RW + CW + 2;
    localparam int S2W = ORW + 1;

    logic [CW-1:0]  row_cnt_q, row_cnt_d;
    logic           mask_q, err_last_q;
    logic           in_xfer, is_end, mask_eff;
    logic [RW-1:0]  row_d;
    logic [S1W-1:0] s1_in, s1_out;
    logic           s1_valid, s2_ready;
    logic [RW-1:0]  s1_row;
    logic           s1_last, s1_mask;
    logic [CW-1:0]  s1_idx;
    logic [ORW-1:0] sm_row, s2_row;
    logic [S2W-1:0] s2_out;

    assign in_xfer   = in_valid && in_ready;
    assign is_end    = (row_cnt_q == CW'(ROW_IN - 1));
    assign row_cnt_d = (in_last || is_end) ? '0 : row_cnt_q + 1'b1;
    // Row 0 uses mask_en directly; later rows use the value latched on row 0.
    assign mask_eff  = (row_cnt_q == '0) ? mask_en : mask_q;
    assign err_last  = err_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q  <= '0;
            mask_q     <= 1'b0;
            err_last_q <= 1'b0;
        end else if (in_xfer) begin
            row_cnt_q <= row_cnt_d;
            if (row_cnt_q == '0) mask_q <= mask_en;
            if (in_last != is_end) err_last_q <= 1'b1;
        end
    end

    always_comb begin
        row_d = in_row;
        for (int j = 0; j < COL_IN; j++) begin
            if (mask_eff && j > int'(row_cnt_q)) begin
                row_d = RW'(set_lane(row_t'(row_d), j, IW, mask_neg(IW)));
            end
        end
    end

    assign s1_in = {row_d, in_last, row_cnt_q, mask_eff};

    softmax_pipe_stage #(.W(S1W)) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (s1_in),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_out)
    );

    assign s1_row  = s1_out[S1W-1 -: RW];
    assign s1_last = s1_out[CW+1];
    assign s1_idx  = s1_out[CW:1];
    assign s1_mask = s1_out[0];

    softmax #(
        .DATA_LENGTH (COL_IN),
        .IW          (IW),
        .OW          (OW)
    ) u_softmax (
        .data_i (s1_row),
        .data_o (sm_row)
    );

    // Hidden lanes are forced to exact zero independent of softmax rounding.
    always_comb begin
        s2_row = sm_row;
        for (int j = 0; j < COL_IN; j++) begin
            if (s1_mask && j > int'(s1_idx)) begin
                s2_row = ORW'(set_lane(row_t'(s2_row), j, OW, 32'(0)));
            end
        end
    end

    softmax_pipe_stage #(.W(S2W)) u_s2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   ({s2_row, s1_last}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_out)
    );

    assign out_row  = s2_out[S2W-1:1];
    assign out_last = s2_out[0];

endmodule

// File: tb/tb_mat_softmax_stream.sv
// Randomised and directed bench for mat_softmax_stream with a row-level reference model.
// Reference: softmax over visible lanes with base-2 weights, hidden lanes exactly zero.
module tb_mat_softmax_stream;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mask_en = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_row = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_row;
    logic         out_last;
    logic         err_last;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] row;
        logic         last;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   m_row  = 0;
    logic m_mask = 1'b0;
    logic m_err  = 1'b0;

    logic [127:0] uniform   = {8{16'h1000}};
    logic [127:0] lane0     = 128'h8000;
    logic [127:0] two_lanes = {96'h0, 16'h4000, 16'h4000};
    logic [127:0] four_lanes = {64'h0, {4{16'h2000}}};
    logic [127:0] ones_row  = {8{16'h0100}};

    always #5 clk = ~clk;

    mat_softmax_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mask_en   (mask_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .err_last  (err_last)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Probability of lane j = 2^-floor(max-x_j) / sum, scaled so 1.0 = 32768.
    function automatic logic [127:0] ref_softmax(input logic [127:0] row,
                                                 input int vis);
        int     x [COLS];
        longint w [COLS];
        longint sum;
        int     mx, k;
        logic [127:0] r;
        for (int j = 0; j < vis; j++) x[j] = int'($signed(row[j*16 +: 16]));
        mx = x[0];
        for (int j = 1; j < vis; j++) if (x[j] > mx) mx = x[j];
        sum = 0;
        for (int j = 0; j < vis; j++) begin
            k    = (mx - x[j]) / 256;
            w[j] = (k < 16) ? (longint'(1) << (15 - k)) : 0;
            sum += w[j];
        end
        r = '0;
        for (int j = 0; j < vis; j++) r[j*16 +: 16] = 16'((w[j] * 32768) / sum);
        return r;
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int j = 0; j < COLS; j++) begin
            if ($urandom % 2 == 0) r[j*16 +: 16] = 16'($urandom);
            else r[j*16 +: 16] = 16'($urandom_range(0, 3072) - 1536);
        end
        return r;
    endfunction

    task automatic model_push();
        rec_t e;
        int   vis;
        logic is_end;
        if (m_row == 0) m_mask = mask_en;
        vis    = (m_mask && m_row < COLS) ? m_row + 1 : COLS;
        e.row  = ref_softmax(in_row, vis);
        e.last = in_last;
        exp_q.push_back(e);
        is_end = (m_row == ROWS - 1);
        if (in_last != is_end) m_err = 1'b1;
        m_row = (in_last || is_end) ? 0 : m_row + 1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_last", 128'(err_last), 128'(m_err));
            if (out_valid && out_ready) begin
                chk("outstanding", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    rec_t e;
                    e = exp_q.pop_front();
                    chk("row", out_row, e.row);
                    chk("last", 128'(out_last), 128'(e.last));
                end
                obs_q.push_back('{out_row, out_last});
            end
            if (in_valid && in_ready) model_push();
        end
    end

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        m_row  = 0;
        m_mask = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        mask_en  = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [127:0] row, input logic last,
                        input logic men);
        int n = 0;
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        mask_en  = men;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept_wait", 128'(n >= 50), 128'(0));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_wait", 128'(n >= 100), 128'(0));
    endtask

    initial begin
        rec_t e;
        int   n;
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_row", out_row, 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_err", 128'(err_last), 128'(0));

        // Latency of an unmasked zero row.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_row    = '0;
        @(negedge clk);
        chk("lat_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_1", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("lat_2", 128'(out_valid), 128'(1));
        chk("zero_row", out_row, uniform);
        drain();

        // Causal matrix of identical rows.
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) send(ones_row, r == ROWS - 1, 1'b1);
        drain();
        chk("mask_cnt", 128'(obs_q.size()), 128'(8));
        chk("mask_row0", obs_q[0].row, lane0);
        chk("mask_row3", obs_q[3].row, four_lanes);
        chk("mask_row7", obs_q[7].row, uniform);

        // Backpressure with three rows offered.
        obs_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        mask_en   = 1'b0;
        in_row    = rand_row();
        @(posedge clk);
        #1 in_row = rand_row();
        @(posedge clk);
        #1 in_row = rand_row();
        @(negedge clk);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_accepted", 128'(exp_q.size()), 128'(2));
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_hold", out_row, exp_q[0].row);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("bp_release", 128'(n >= 50), 128'(0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("bp_count", 128'(obs_q.size()), 128'(3));

        // Early in_last on row 2, then a fresh masked matrix.
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) send(rand_row(), r == 2, 1'b0);
        @(negedge clk);
        chk("err_rise", 128'(err_last), 128'(1));
        @(posedge clk);
        #1;
        for (int r = 0; r < ROWS; r++) send(ones_row, r == ROWS - 1, 1'b1);
        drain();
        chk("err_next_row0", obs_q[3].row, lane0);
        chk("err_next_row1", obs_q[4].row, two_lanes);
        chk("err_sticky", 128'(err_last), 128'(1));

        // mask_en drops mid-matrix; next matrix unmasked.
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) send(rand_row(), r == ROWS - 1, r < 4);
        for (int r = 0; r < ROWS; r++) send(ones_row, r == ROWS - 1, 1'b0);
        drain();
        e = obs_q[5];
        chk("tog_row5_hidden", 128'(e.row[127:96]), 128'(0));
        chk("tog_next_row0", obs_q[8].row, uniform);

        // Reset with two rows in flight.
        do_reset();
        out_ready = 1'b0;
        send(rand_row(), 1'b0, 1'b0);
        send(rand_row(), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_ready", 128'(in_ready), 128'(1));
        clear_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_stale", 128'(obs_q.size()), 128'(0));
        send(ones_row, 1'b0, 1'b1);
        drain();
        chk("rst_row0", obs_q[0].row, lane0);

        // Random traffic with random stalls.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_row    = rand_row();
            in_last   = ($urandom % 8) == 0;
            mask_en   = $urandom % 2;
            out_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("rand_left", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
